// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants and the fetch FSM state encoding.
package riscv_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned OP_EFF_WIDTH = 5;
    localparam int unsigned FUNCT3_WIDTH = 3;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t FETCH_REQ  = 2'd0;
    localparam fetch_state_t FETCH_WAIT = 2'd1;
    localparam fetch_state_t FETCH_DROP = 2'd2;

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry skid register that parks an instruction response while decode is stalled.
module fetch_hold_buffer #(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            drain,
    input  logic            clear,
    input  logic [31:0]     inst_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc
);

    import riscv_pkg::*;

    // Load beats drain so a drain and refill in the same cycle keeps the new word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= inst_in;
            pc    <= pc_in;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem handshake, hold buffer and IF/ID.
module fetch_unit #(
    parameter int unsigned     XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int unsigned     OP_EFF_WIDTH = riscv_pkg::OP_EFF_WIDTH,
    parameter int unsigned     FUNCT3_WIDTH = riscv_pkg::FUNCT3_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    PCSel,
    input  logic [XLEN-1:0]         pc_target,
    input  logic                    stall_D,
    input  logic                    flush_D,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_rsp_valid,
    input  logic [31:0]             imem_rsp_data,
    output logic                    valid_D,
    output logic [31:0]             inst_D,
    output logic [XLEN-1:0]         pc_D,
    output logic [XLEN-1:0]         pc_plus4_D,
    output logic [OP_EFF_WIDTH-1:0] opcode_eff_D,
    output logic [FUNCT3_WIDTH-1:0] funct3_D,
    output logic                    funct7_fif_D
);

    import riscv_pkg::*;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_t    state_q, state_d;
    logic            started_q;
    logic [XLEN-1:0] pc_f_q;
    logic [XLEN-1:0] pc_inflight_q;

    logic            req_valid;
    logic            req_fire;
    logic            rsp_take;
    logic            hold_valid;
    logic            hold_load;
    logic            hold_drain;
    logic [31:0]     hold_inst;
    logic [XLEN-1:0] hold_pc;

    always_comb begin
        rsp_take   = (state_q == FETCH_WAIT) && imem_rsp_valid && !PCSel;
        hold_drain = hold_valid && !stall_D;
        // A response can only bypass the buffer when decode can take it directly.
        hold_load  = rsp_take && (stall_D || hold_valid);

        req_valid = 1'b0;
        if (started_q && !PCSel) begin
            unique case (state_q)
                FETCH_REQ:  req_valid = !hold_valid || !stall_D;
                FETCH_WAIT: req_valid = imem_rsp_valid && !stall_D && !hold_valid;
                default:    req_valid = 1'b0;
            endcase
        end
        req_fire = req_valid && imem_req_ready;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH_REQ: begin
                if (req_fire) state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                // A redirect that coincides with the response leaves nothing to drop.
                if (PCSel)               state_d = imem_rsp_valid ? FETCH_REQ : FETCH_DROP;
                else if (imem_rsp_valid) state_d = req_fire ? FETCH_WAIT : FETCH_REQ;
            end
            FETCH_DROP: begin
                if (imem_rsp_valid) state_d = FETCH_REQ;
            end
            default: state_d = FETCH_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH_REQ;
            started_q     <= 1'b0;
            pc_f_q        <= RESET_PC & ALIGN_MASK;
            pc_inflight_q <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            if (PCSel) begin
                pc_f_q <= pc_target & ALIGN_MASK;
            end else if (req_fire) begin
                pc_inflight_q <= pc_f_q;
                pc_f_q        <= pc_f_q + XLEN'(4);
            end
        end
    end

    fetch_hold_buffer #(
        .XLEN (XLEN)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load    (hold_load),
        .drain   (hold_drain),
        .clear   (PCSel),
        .inst_in (imem_rsp_data),
        .pc_in   (pc_inflight_q),
        .valid   (hold_valid),
        .inst    (hold_inst),
        .pc      (hold_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_D    <= 1'b0;
            inst_D     <= NOP_INST;
            pc_D       <= '0;
            pc_plus4_D <= XLEN'(4);
        end else if (PCSel || flush_D) begin
            valid_D <= 1'b0;
            inst_D  <= NOP_INST;
        end else if (!stall_D) begin
            if (hold_valid) begin
                valid_D    <= 1'b1;
                inst_D     <= hold_inst;
                pc_D       <= hold_pc;
                pc_plus4_D <= hold_pc + XLEN'(4);
            end else if (rsp_take) begin
                valid_D    <= 1'b1;
                inst_D     <= imem_rsp_data;
                pc_D       <= pc_inflight_q;
                pc_plus4_D <= pc_inflight_q + XLEN'(4);
            end else begin
                valid_D <= 1'b0;
                inst_D  <= NOP_INST;
            end
        end
    end

    assign imem_req_valid = req_valid;
    assign imem_addr      = pc_f_q;
    assign opcode_eff_D   = inst_D[2 +: OP_EFF_WIDTH];
    assign funct3_D       = inst_D[12 +: FUNCT3_WIDTH];
    assign funct7_fif_D   = inst_D[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model pushes expected PCs, IF/ID monitor pops them.
module tb_fetch_unit;

    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCSel = 1'b0;
    logic [31:0] pc_target = '0;
    logic        stall_D = 1'b0;
    logic        flush_D = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        valid_D;
    logic [31:0] inst_D;
    logic [31:0] pc_D;
    logic [31:0] pc_plus4_D;
    logic [4:0]  opcode_eff_D;
    logic [2:0]  funct3_D;
    logic        funct7_fif_D;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .PCSel          (PCSel),
        .pc_target      (pc_target),
        .stall_D        (stall_D),
        .flush_D        (flush_D),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .valid_D        (valid_D),
        .inst_D         (inst_D),
        .pc_D           (pc_D),
        .pc_plus4_D     (pc_plus4_D),
        .opcode_eff_D   (opcode_eff_D),
        .funct3_D       (funct3_D),
        .funct7_fif_D   (funct7_fif_D)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A4;
    endfunction

    // Memory model with programmable response latency.
    logic        mem_pending;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat = 0;
    logic [31:0] model_pc = '0;
    logic [31:0] exp_q[$];
    int          acc_cnt = 0;
    logic [31:0] last_acc = '0;
    logic [31:0] wrap_addr = 32'hDEAD_BEEF;

    assign imem_rsp_valid = mem_pending && (mem_cnt == 0);
    assign imem_rsp_data  = mem_word(mem_addr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_pending <= 1'b0;
            mem_cnt     <= 0;
            mem_addr    <= '0;
            exp_q.delete();
            model_pc = 32'h0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_addr, model_pc);
                check("one_outstanding", {31'b0, mem_pending && !imem_rsp_valid}, 32'd0);
                if (acc_cnt > 0 && last_acc == 32'hFFFF_FFFC) wrap_addr = imem_addr;
                exp_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
                acc_cnt++;
                last_acc = imem_addr;
                mem_pending <= 1'b1;
                mem_addr    <= imem_addr;
                mem_cnt     <= lat;
            end else if (imem_rsp_valid) begin
                mem_pending <= 1'b0;
            end else if (mem_pending && mem_cnt != 0) begin
                mem_cnt <= mem_cnt - 1;
            end
            if (PCSel) begin
                exp_q.delete();
                model_pc = pc_target & ~32'h3;
            end
        end
    end

    // IF/ID monitor, sampled just after each rising edge.
    logic [31:0] last_inst = NOP_INST;
    logic [31:0] last_pc = '0;

    always @(posedge clk) begin
        logic [31:0] e;
        logic [31:0] w;
        #1;
        if (!rst) begin
            if (PCSel) begin
                check("redir_bubble_v", {31'b0, valid_D}, 32'd0);
                check("redir_bubble_i", inst_D, NOP_INST);
            end else if (flush_D) begin
                check("flush_bubble", {31'b0, valid_D}, 32'd0);
            end else if (stall_D) begin
                check("stall_inst", inst_D, last_inst);
                check("stall_pc", pc_D, last_pc);
            end else if (valid_D) begin
                check("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    w = mem_word(e);
                    check("sb_pc", pc_D, e);
                    check("sb_inst", inst_D, w);
                    check("sb_pc4", pc_plus4_D, e + 32'd4);
                    check("sb_opc", {27'b0, opcode_eff_D}, {27'b0, w[6:2]});
                    check("sb_f3", {29'b0, funct3_D}, {29'b0, w[14:12]});
                    check("sb_f7", {31'b0, funct7_fif_D}, {31'b0, w[30]});
                end
            end
        end
        last_inst = inst_D;
        last_pc   = pc_D;
    end

    task automatic wait_in_wait();
        int n = 0;
        while (!(mem_pending && !imem_rsp_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_found", {31'b0, mem_pending && !imem_rsp_valid}, 32'd1);
    endtask

    task automatic wait_accept();
        int c0 = acc_cnt;
        int n = 0;
        while (acc_cnt == c0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_seen", {31'b0, acc_cnt != c0}, 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, valid_D}, 32'd0);
        check("rst_inst", inst_D, NOP_INST);
        check("rst_pc", pc_D, 32'd0);
        check("rst_pc4", pc_plus4_D, 32'd4);
        check("rst_req", {31'b0, imem_req_valid}, 32'd0);
        check("rst_opc", {27'b0, opcode_eff_D}, 32'd4);
        check("rst_f3", {29'b0, funct3_D}, 32'd0);

        imem_req_ready = 1'b1;
        rst = 1'b0;
        #1;
        check("req_pre_edge", {31'b0, imem_req_valid}, 32'd0);
        @(negedge clk);
        check("req_rise", {31'b0, imem_req_valid}, 32'd1);
        check("req_first", imem_addr, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("thru_valid", {31'b0, valid_D}, 32'd1);
            check("thru_pc", pc_D, 32'(i * 4));
        end

        stall_D = 1'b1;
        repeat (3) @(negedge clk);
        stall_D = 1'b0;
        @(negedge clk);
        check("unstall_valid", {31'b0, valid_D}, 32'd1);
        repeat (3) @(negedge clk);

        stall_D = 1'b1;
        @(negedge clk);
        flush_D = 1'b1;
        @(negedge clk);
        flush_D = 1'b0;
        @(negedge clk);
        stall_D = 1'b0;
        repeat (4) @(negedge clk);

        lat = 2;
        repeat (2) @(negedge clk);
        wait_in_wait();
        PCSel = 1'b1;
        pc_target = 32'h0000_0103;
        @(negedge clk);
        PCSel = 1'b0;
        check("redir_valid", {31'b0, valid_D}, 32'd0);
        wait_accept();
        check("redir_addr", last_acc, 32'h0000_0100);
        repeat (10) @(negedge clk);

        lat = 0;
        repeat (4) @(negedge clk);
        stall_D = 1'b1;
        @(negedge clk);
        PCSel = 1'b1;
        pc_target = 32'h0000_0200;
        @(negedge clk);
        PCSel = 1'b0;
        check("redir_stall_i", inst_D, NOP_INST);
        check("redir_stall_v", {31'b0, valid_D}, 32'd0);
        stall_D = 1'b0;
        repeat (6) @(negedge clk);

        PCSel = 1'b1;
        pc_target = 32'hFFFF_FFF8;
        @(negedge clk);
        PCSel = 1'b0;
        repeat (8) @(negedge clk);
        check("wrap_addr", wrap_addr, 32'd0);

        lat = 3;
        repeat (2) @(negedge clk);
        wait_in_wait();
        rst = 1'b1;
        #1;
        check("rst_async_v", {31'b0, valid_D}, 32'd0);
        check("rst_async_req", {31'b0, imem_req_valid}, 32'd0);
        check("rst_async_i", inst_D, NOP_INST);
        @(negedge clk);
        lat = 0;
        rst = 1'b0;
        wait_accept();
        check("rst_first_addr", last_acc, 32'd0);
        repeat (6) @(negedge clk);

        imem_req_ready = 1'b0;
        repeat (6) @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Owns the PC, issues requests to instruction memory over a valid/ready handshake, and captures responses into the IF/ID register.
- Presents the decoded instruction fields (opcode_eff, funct3, funct7_fif) to control_unit in D.
- Consumes PCSel and target from EX to redirect fetch; obeys stall/flush from the hazard unit.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- OP_EFF_WIDTH, 5, width of opcode_eff field (inst[6:2]).
- FUNCT3_WIDTH, 3, width of funct3 field (inst[14:12]).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCSel  in  1  EX redirect request; 1 = take pc_target.
- pc_target  in  XLEN  redirect address from EX ALU.
- stall_D  in  1  hazard unit: hold IF/ID contents.
- flush_D  in  1  hazard unit: turn IF/ID into a bubble.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  XLEN  request address, word aligned.
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  32  instruction word.
- valid_D  out  1  IF/ID holds a real instruction.
- inst_D  out  32  IF/ID instruction.
- pc_D  out  XLEN  PC of inst_D.
- pc_plus4_D  out  XLEN  pc_D+4 (for JAL/JALR writeback).
- opcode_eff_D  out  OP_EFF_WIDTH  inst_D[6:2].
- funct3_D  out  FUNCT3_WIDTH  inst_D[14:12].
- funct7_fif_D  out  1  inst_D[30].

Behaviour:
- Reset (async, while rst=1):
  - pc_F = RESET_PC.
  - FSM = REQ, imem_req_valid = 0.
  - valid_D = 0, inst_D = NOP 32'h0000_0013, pc_D = 0, pc_plus4_D = 4.
  - Hold buffer empty.
- Reset deassertion and memory state:
  - imem_req_valid rises on the first clk edge after rst deasserts.
  - imem shares rst, so no response is pending across reset.
  - Reset mid-transaction discards everything in flight.
- Outstanding requests: at most one. pc_inflight records the address of the accepted request.
- FSM states:
  - REQ: imem_req_valid = 1 only if the hold buffer is empty or will drain this cycle. imem_addr = pc_F. On valid&&ready: pc_inflight <= pc_F, pc_F <= pc_F+4, go WAIT.
  - WAIT: imem_req_valid = 0 unless imem_rsp_valid arrives this cycle and capture space exists; in that case a new request may issue in the same cycle (back-to-back). Response returns to REQ, or stays WAIT if a new request was accepted.
  - DROP: entered when a redirect occurs while in WAIT. The next imem_rsp_valid is discarded, then go REQ.
- Throughput: single-cycle-latency memory, no stalls → 1 instruction/cycle. Request accepted at cycle n, response at n+1, IF/ID valid at n+2.
- Response capture:
  - If stall_D=0, the response loads IF/ID (inst, pc_inflight, pc_inflight+4, valid_D=1).
  - If stall_D=1, the response loads the 1-entry hold buffer.
  - When stall_D falls, IF/ID loads from the hold buffer first; the buffer empties the same cycle.
  - Hold buffer full: no new request issued.
- Redirect (PCSel=1):
  - pc_F <= {pc_target[XLEN-1:2], 2'b00}; low bits are silently cleared.
  - IF/ID becomes a bubble (valid_D=0, inst_D=NOP). Hold buffer cleared.
  - WAIT → DROP, or stays DROP. A response arriving in that same cycle is also discarded.
  - No imem request is issued in the redirect cycle.
- flush_D=1 without PCSel: IF/ID becomes a bubble; fetch state unchanged.
- Priority, highest first: rst > PCSel > flush_D > stall_D > normal capture. PCSel with stall_D → redirect still wins and IF/ID is bubbled.
- Wrap-around: pc_F+4 wraps modulo 2^XLEN with no error.
- Decoded field outputs are pure slices of inst_D. A bubble therefore presents NOP fields (opcode_eff=5'b00100, funct3=0).

Decomposition:
- Shared package riscv_pkg:
  - XLEN, NOP_INST = 32'h0000_0013, OP_EFF_WIDTH, FUNCT3_WIDTH.
  - Fetch FSM state encoding {REQ, WAIT, DROP}.
- Sub-module fetch_hold_buffer: 1-entry skid register {inst, pc, valid} with load/drain/clear.
- FSM, PC register and IF/ID register live in fetch_unit.

Test Plan:
- Reset, then 4 fetches with zero-wait imem → imem_addr 0,4,8,C on consecutive cycles; valid_D=1 from cycle 2 with pc_D 0,4,8,C back-to-back.
- stall_D held for 3 cycles while a response arrives → inst_D and pc_D frozen; buffered word appears the cycle after stall_D drops; no address skipped or duplicated.
- PCSel=1, pc_target=0x0000_0103 while in WAIT → next imem_addr=0x100; the in-flight response is dropped; valid_D=0 for the redirect cycle; first valid pc_D=0x100.
- PCSel=1 and stall_D=1 in the same cycle → redirect taken, IF/ID bubbled (inst_D=0x13), hold buffer cleared.
- pc_F=0xFFFF_FFFC fetch → next imem_addr=0x0000_0000.
- rst asserted mid-WAIT → valid_D=0 and imem_req_valid=0 immediately, asynchronously; first request after release is RESET_PC.
